bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Parallel-to-serial front end for the lab-5 1-bit sequence FSMs; drives their In_Data input with one bit per clock.
- Accepts words over a valid/ready handshake, each with its own bit length.
- Holds one pending word, so back-to-back words stream with no idle cycle between them.
- Out_Valid tells downstream and the bench which cycles carry real bits.

Parameters:
WIDTH, 8, maximum word width in bits (>=2)
LSB_FIRST, 0, 0: send In_Word[Len-1] down to [0]; 1: send [0] up to [Len-1]
IDLE_BIT, 0, value driven on Out_Data while no word is active
LW, $clog2(WIDTH+1), width of the length field (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
In_Valid  input  1  upstream word valid
In_Ready  output  1  block can accept a word this cycle
In_Word  input  WIDTH  parallel word; bits at or above In_Len are ignored
In_Len  input  LW  number of bits to send, 1..WIDTH
Out_Data  output  1  serial bit, connects to FSM In_Data
Out_Valid  output  1  Out_Data carries a real bit this cycle
Word_Done  output  1  high during the last bit of each word
Busy  output  1  active word or pending word present

Behaviour:
- Storage:
  - active shifter: sh[WIDTH], cnt = bits remaining including the current one, act flag;
  - pending slot: pend_word, pend_len, pend_v.
- Reset (rst=0, asynchronous): act=0, pend_v=0, cnt=0.
  - Outputs immediately: Out_Data=IDLE_BIT, Out_Valid=0, Word_Done=0, Busy=0, In_Ready=1.
  - Reset mid-word discards the active and pending words; no partial-word completion.
- Handshake:
  - In_Ready = !pend_v (combinational).
  - Transfer happens on a rising edge with In_Valid && In_Ready.
  - In_Word/In_Len are sampled only at transfer. Upstream must hold them while In_Valid=1 and In_Ready=0.
- Length rules:
  - In_Len=0 or In_Len>WIDTH is clamped to WIDTH.
  - Bits of In_Word at or above the effective length never appear on Out_Data.
- Outputs:
  - Out_Data = act ? current bit : IDLE_BIT.
  - Out_Valid = act.
  - Word_Done = act && cnt==1.
  - Busy = act || pend_v.
  - All outputs are functions of registers only; no combinational path from the In_* ports.
- Per rising edge, in priority order:
  1. act && cnt>1: shift to the next bit, cnt-1. A transfer this edge writes the pending slot.
  2. (!act) or (act && cnt==1) [finishing]:
     - if pend_v: load the pending word into the shifter, pend_v=0. A simultaneous transfer is impossible because In_Ready=0.
     - else if transfer: load the input word directly into the shifter, act=1.
     - else: act=0.
- Latency:
  - Word accepted at edge N while idle: its first bit is on Out_Data from edge N until edge N+1.
  - Each bit lasts exactly one cycle.
  - A word of length L occupies L consecutive Out_Valid cycles.
- Back-to-back: the next word's first bit follows the previous word's last bit with zero gap, whether it comes from the pending slot or via a direct load on the finishing edge.
- Full: pend_v=1 and act=1 forces In_Ready=0. In_Ready rises the cycle after the pending word moves to the shifter.
- Len=1 word: Out_Valid and Word_Done both high for one cycle.
- cnt never wraps; shifter contents outside the active length are don't-care.

Test Plan:
1. Reset then idle, WIDTH=8, IDLE_BIT=0 -> Out_Data=0, Out_Valid=0, In_Ready=1, Busy=0 for 5 cycles.
2. MSB-first, word 8'h55 with Len=8 -> Out_Data 0,1,0,1,0,1,0,1 on 8 consecutive Out_Valid cycles; Word_Done only on the 8th; Busy falls after.
3. Back-to-back: 8'h57 Len=8 held valid, then 8'h0C Len=3 (sends 1,0,0) -> continuous stream 0,1,0,1,0,1,1,1,1,0,0 with no gap.
   - In_Ready low from the second transfer until the pending word loads.
   - Word_Done high on cycles 8 and 11.
4. LSB_FIRST=1, 8'hB1 with Len=4 -> Out_Data 1,0,0,0; upper nibble never emitted. Len=0 with 8'h80 -> 8 bits, last bit =1.
5. Len=1 words offered every cycle, alternating 1/0 -> Out_Data 1,0,1,0…; Out_Valid and Word_Done continuously high; In_Ready never low.
6. Assert rst low during bit 3 of a word, with a pending word present -> outputs return to reset values without waiting for a clock edge.
   - After release, no stale bits are emitted.
   - The next accepted word starts cleanly one cycle after transfer.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word pending slot so consecutive words stream
// back-to-back; each word carries its own bit length (0 or >WIDTH means WIDTH).
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0,
   parameter bit IDLE_BIT  = 1'b0,
   localparam int LW       = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [WIDTH-1:0] In_Word,
   input  logic [LW-1:0]    In_Len,
   output logic             Out_Data,
   output logic             Out_Valid,
   output logic             Word_Done,
   output logic             Busy
);

   localparam logic [LW-1:0] FULL_LEN = LW'(WIDTH);

   logic [WIDTH-1:0] r_sh, w_sh_d;
   logic [LW-1:0]    r_cnt, w_cnt_d;
   logic             r_act, w_act_d;
   logic [WIDTH-1:0] r_pend_word, w_pend_word_d;
   logic [LW-1:0]    r_pend_len, w_pend_len_d;
   logic             r_pend_v, w_pend_v_d;

   logic             w_xfer;
   logic [LW-1:0]    w_in_len;
   logic             w_cur;

   // Current bit always sits at a fixed end of the shifter; MSB-first words are left-justified.
   function automatic logic [WIDTH-1:0] f_align(input logic [WIDTH-1:0] word,
                                                input logic [LW-1:0]    len);
      if (LSB_FIRST) return word;
      else return word << (FULL_LEN - len);
   endfunction

   always_comb begin
      w_xfer   = In_Valid && !r_pend_v;
      w_in_len = ((In_Len == '0) || (In_Len > FULL_LEN)) ? FULL_LEN : In_Len;
      w_cur    = LSB_FIRST ? r_sh[0] : r_sh[WIDTH-1];
   end

   always_comb begin
      w_sh_d        = r_sh;
      w_cnt_d       = r_cnt;
      w_act_d       = r_act;
      w_pend_word_d = r_pend_word;
      w_pend_len_d  = r_pend_len;
      w_pend_v_d    = r_pend_v;

      if (r_act && (r_cnt > LW'(1))) begin
         w_sh_d  = LSB_FIRST ? (r_sh >> 1) : (r_sh << 1);
         w_cnt_d = r_cnt - LW'(1);
         if (w_xfer) begin
            w_pend_word_d = In_Word;
            w_pend_len_d  = w_in_len;
            w_pend_v_d    = 1'b1;
         end
      end else if (r_pend_v) begin
         w_sh_d     = f_align(r_pend_word, r_pend_len);
         w_cnt_d    = r_pend_len;
         w_act_d    = 1'b1;
         w_pend_v_d = 1'b0;
      end else if (w_xfer) begin
         w_sh_d  = f_align(In_Word, w_in_len);
         w_cnt_d = w_in_len;
         w_act_d = 1'b1;
      end else begin
         w_act_d = 1'b0;
         w_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sh        <= '0;
         r_cnt       <= '0;
         r_act       <= 1'b0;
         r_pend_word <= '0;
         r_pend_len  <= '0;
         r_pend_v    <= 1'b0;
      end else begin
         r_sh        <= w_sh_d;
         r_cnt       <= w_cnt_d;
         r_act       <= w_act_d;
         r_pend_word <= w_pend_word_d;
         r_pend_len  <= w_pend_len_d;
         r_pend_v    <= w_pend_v_d;
      end
   end

   always_comb begin
      In_Ready  = !r_pend_v;
      Out_Data  = r_act ? w_cur : IDLE_BIT;
      Out_Valid = r_act;
      Word_Done = r_act && (r_cnt == LW'(1));
      Busy      = r_act || r_pend_v;
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream; every
// accepted word pushes its expected bit sequence, popped as Out_Valid bits appear.
module tb_bit_serializer;

   localparam int WIDTH = 8;
   localparam int LW    = 4;

   typedef struct packed {
      logic d;
      logic done;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] in_word;
   logic [LW-1:0]    in_len;
   logic m_ready, m_data, m_valid, m_done, m_busy;
   logic l_ready, l_data, l_valid, l_done, l_busy;

   exp_t q_m[$];
   exp_t q_l[$];
   exp_t e_mon;

   int n_tests  = 0;
   int n_fail   = 0;
   int n_wait   = 0;
   int run_len  = 0;
   int last_run = -1;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_msb (
      .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Ready(m_ready), .In_Word(in_word),
      .In_Len(in_len), .Out_Data(m_data), .Out_Valid(m_valid), .Word_Done(m_done),
      .Busy(m_busy)
   );

   bit_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_lsb (
      .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Ready(l_ready), .In_Word(in_word),
      .In_Len(in_len), .Out_Data(l_data), .Out_Valid(l_valid), .Word_Done(l_done),
      .Busy(l_busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [7:0] w, input logic [3:0] len);
      int   eff;
      exp_t e;
      eff = ((len == 0) || (len > 8)) ? 8 : int'(len);
      for (int i = 0; i < eff; i++) begin
         e.done = (i == eff - 1);
         e.d    = w[eff-1-i];
         q_m.push_back(e);
         e.d    = w[i];
         q_l.push_back(e);
      end
   endtask

   // Called at #1 after a rising edge; returns #1 after the edge that made the transfer.
   task automatic send(input logic [7:0] w, input logic [3:0] len);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_word  = w;
      in_len   = len;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (m_ready) begin
            push_word(w, len);
            ok = 1'b1;
         end else begin
            n_wait++;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check_eq("send_ready_timeout", m_ready, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (!m_busy && !l_busy && q_m.size() == 0 && q_l.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check_eq("idle_msb_busy", m_busy, 0);
      check_eq("idle_lsb_busy", l_busy, 0);
      check_eq("idle_msb_left", q_m.size(), 0);
      check_eq("idle_lsb_left", q_l.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            run_len = 0;
         end else begin
            if (m_valid) begin
               run_len++;
               if (q_m.size() == 0) begin
                  check_eq("msb_unexpected_valid", m_valid, 0);
               end else begin
                  e_mon = q_m.pop_front();
                  check_eq("msb_data", m_data, e_mon.d);
                  check_eq("msb_done", m_done, e_mon.done);
               end
            end else begin
               if (run_len != 0) last_run = run_len;
               run_len = 0;
               check_eq("msb_idle_data", m_data, 0);
               check_eq("msb_idle_done", m_done, 0);
            end
            if (l_valid) begin
               if (q_l.size() == 0) begin
                  check_eq("lsb_unexpected_valid", l_valid, 0);
               end else begin
                  e_mon = q_l.pop_front();
                  check_eq("lsb_data", l_data, e_mon.d);
                  check_eq("lsb_done", l_done, e_mon.done);
               end
            end else begin
               check_eq("lsb_idle_data", l_data, 0);
               check_eq("lsb_idle_done", l_done, 0);
            end
         end
      end
   end

   initial begin
      int cnt;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_word  = '0;
      in_len   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Reset then idle
      for (int i = 0; i < 5; i++) begin
         check_eq("t1_data", m_data, 0);
         check_eq("t1_valid", m_valid, 0);
         check_eq("t1_ready", m_ready, 1);
         check_eq("t1_busy", m_busy, 0);
         check_eq("t1_lsb_valid", l_valid, 0);
         @(posedge clk);
         #1;
      end

      // Single full-width word, first bit right after the transfer edge
      last_run = -1;
      send(8'h55, 4'd8);
      in_valid = 1'b0;
      check_eq("t2_first_valid", m_valid, 1);
      check_eq("t2_first_bit_msb", m_data, 0);
      check_eq("t2_first_bit_lsb", l_data, 1);
      wait_idle();
      check_eq("t2_run_len", last_run, 8);

      // Back-to-back through the pending slot
      last_run = -1;
      send(8'h57, 4'd8);
      send(8'h0C, 4'd3);
      in_valid = 1'b0;
      check_eq("t3_ready_low", m_ready, 0);
      check_eq("t3_busy", m_busy, 1);
      cnt = 0;
      for (int i = 0; i < 20 && !m_ready; i++) begin
         cnt++;
         @(posedge clk);
         #1;
      end
      check_eq("t3_ready_low_cycles", cnt, 7);
      wait_idle();
      check_eq("t3_run_len", last_run, 11);

      // Short length masks upper bits; zero length means full width
      last_run = -1;
      send(8'hB1, 4'd4);
      in_valid = 1'b0;
      wait_idle();
      check_eq("t4_run_len4", last_run, 4);
      last_run = -1;
      send(8'h80, 4'd0);
      in_valid = 1'b0;
      wait_idle();
      check_eq("t4_run_len0", last_run, 8);
      last_run = -1;
      send(8'hF3, 4'd12);
      in_valid = 1'b0;
      wait_idle();
      check_eq("t4_run_len12", last_run, 8);

      // Len=1 every cycle: direct loads on each finishing edge, never stalls
      last_run = -1;
      n_wait   = 0;
      for (int i = 0; i < 8; i++) begin
         send({7'($urandom), ((i % 2) == 0) ? 1'b1 : 1'b0}, 4'd1);
      end
      in_valid = 1'b0;
      check_eq("t5_wait_cycles", n_wait, 0);
      wait_idle();
      check_eq("t5_run_len", last_run, 8);

      // Asynchronous reset mid-word with a pending word
      send(8'hA5, 4'd8);
      send(8'h3C, 4'd8);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("t6_busy_before", m_busy, 1);
      check_eq("t6_ready_before", m_ready, 0);
      rst = 1'b0;
      #1;
      check_eq("t6_rst_valid", m_valid, 0);
      check_eq("t6_rst_data", m_data, 0);
      check_eq("t6_rst_done", m_done, 0);
      check_eq("t6_rst_busy", m_busy, 0);
      check_eq("t6_rst_ready", m_ready, 1);
      check_eq("t6_rst_lsb_valid", l_valid, 0);
      q_m.delete();
      q_l.delete();
      #4;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check_eq("t6_no_stale_valid", m_valid, 0);
         check_eq("t6_no_stale_busy", l_busy, 0);
      end
      last_run = -1;
      send(8'hC3, 4'd5);
      in_valid = 1'b0;
      check_eq("t6_new_valid", m_valid, 1);
      check_eq("t6_new_bit_msb", m_data, 0);
      check_eq("t6_new_bit_lsb", l_data, 1);
      wait_idle();
      check_eq("t6_run_len", last_run, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
